timer_mmio: RTL and testbench

Memory-mapped timer/compare peripheral on the uniciclo CPU's data bus. It decodes the data-bus address, write-enable, byte-enable and write-data signals in a window at `BASE_ADDR`, and returns read data for that window. It runs a prescaled 32-bit counter with a compare match. A sticky match flag drives one bit of the CPU's `iPendingInterrupt[7:0]` input.

---
 rtl/timer_mmio.sv | 118 +++++++++++
 tb/tb_timer_mmio.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_mmio.sv
// rtl/timer_mmio.sv - memory-mapped prescaled timer with compare match and sticky irq flag
// Register window on the CPU data bus; reads are combinational, writes land on the clock edge.
module timer_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int unsigned IRQ_BIT   = 7
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oSelected,
  output logic [7:0]  oPendingInterrupt
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_PCNT   = 3'd5;
  localparam logic [2:0] IRQ_IDX    = IRQ_BIT[2:0];

  logic [2:0]  ctrl;
  logic [15:0] presc;
  logic [15:0] pcnt;
  logic [31:0] count;
  logic [31:0] cmp;
  logic        flag;

  logic [2:0]  offset;
  logic        wrEn;
  logic        tick;
  logic        match;
  logic        flagClear;
  logic [31:0] laneMask;
  logic [31:0] countMerged;
  logic [31:0] cmpMerged;
  logic        unusedAddrBits;

  assign oSelected      = (iAddress[31:5] == BASE_ADDR[31:5]);
  assign offset         = iAddress[4:2];
  assign wrEn           = iWriteEnable & oSelected;
  assign tick           = ctrl[0] & (pcnt == presc);
  assign match          = (count == cmp);
  assign flagClear      = wrEn & (offset == OFF_STATUS) & iByteEnable[0] & iWriteData[0];
  assign unusedAddrBits = ^iAddress[1:0];

  assign laneMask = {{8{iByteEnable[3]}}, {8{iByteEnable[2]}},
                     {8{iByteEnable[1]}}, {8{iByteEnable[0]}}};
  assign countMerged = (count & ~laneMask) | (iWriteData & laneMask);
  assign cmpMerged   = (cmp & ~laneMask) | (iWriteData & laneMask);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ctrl  <= 3'd0;
      presc <= 16'd0;
      pcnt  <= 16'd0;
      count <= 32'd0;
      cmp   <= 32'hFFFF_FFFF;
      flag  <= 1'b0;
    end else begin
      if (wrEn && offset == OFF_CTRL && iByteEnable[0])
        ctrl <= iWriteData[2:0];

      if (wrEn && offset == OFF_PRESC) begin
        if (iByteEnable[0]) presc[7:0]  <= iWriteData[7:0];
        if (iByteEnable[1]) presc[15:8] <= iWriteData[15:8];
      end

      // Reprogramming the divider restarts the current prescale period.
      if (wrEn && offset == OFF_PRESC)
        pcnt <= 16'd0;
      else if (tick)
        pcnt <= 16'd0;
      else if (ctrl[0])
        pcnt <= pcnt + 16'd1;

      // A bus write to COUNT beats the tick update, including the reload.
      if (wrEn && offset == OFF_COUNT)
        count <= countMerged;
      else if (tick)
        count <= (match && ctrl[1]) ? 32'd0 : count + 32'd1;

      if (wrEn && offset == OFF_CMP)
        cmp <= cmpMerged;

      if (tick && match)
        flag <= 1'b1;
      else if (flagClear)
        flag <= 1'b0;
    end
  end

  always_comb begin
    oReadData = 32'd0;
    if (oSelected && iReadEnable) begin
      case (offset)
        OFF_CTRL:   oReadData = {29'd0, ctrl};
        OFF_PRESC:  oReadData = {16'd0, presc};
        OFF_COUNT:  oReadData = count;
        OFF_CMP:    oReadData = cmp;
        OFF_STATUS: oReadData = {31'd0, flag};
        OFF_PCNT:   oReadData = {16'd0, pcnt};
        default:    oReadData = 32'd0;
      endcase
    end
  end

  always_comb begin
    oPendingInterrupt          = 8'd0;
    oPendingInterrupt[IRQ_IDX] = flag & ctrl[2];
  end

endmodule

// File: tb/tb_timer_mmio.sv
// tb/tb_timer_mmio.sv - directed bench for timer_mmio with a table-driven register model
// The model keeps the register file as an array indexed by offset and is checked every cycle.
module tb_timer_mmio;

  localparam logic [31:0] BASE = 32'hFF20_0000;

  logic        iCLK;
  logic        iRST;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oSelected;
  logic [7:0]  oPendingInterrupt;

  int total = 0;
  int bad   = 0;

  timer_mmio #(.BASE_ADDR(BASE), .IRQ_BIT(7)) dut (
    .iCLK(iCLK), .iRST(iRST), .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
    .oReadData(oReadData), .oSelected(oSelected), .oPendingInterrupt(oPendingInterrupt)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Model register file: 0 CTRL, 1 PRESC, 2 COUNT, 3 CMP, 4 FLAG, 5 PCNT.
  logic [31:0] mRegs [0:7];
  logic [31:0] mNxt  [0:7];
  logic [31:0] wMask [0:7];
  logic        modelValid = 1'b0;
  logic        mWr, mTick, mHit;
  logic [2:0]  mOff;
  logic [31:0] mLane, mUse;

  initial begin
    wMask[0] = 32'h7;      wMask[1] = 32'hFFFF;
    wMask[2] = 32'hFFFF_FFFF; wMask[3] = 32'hFFFF_FFFF;
    wMask[4] = 32'h0; wMask[5] = 32'h0; wMask[6] = 32'h0; wMask[7] = 32'h0;
    for (int i = 0; i < 8; i++) mRegs[i] = 32'h0;
  end

  function automatic logic [31:0] addrOf(input int off);
    return BASE + 32'(off) * 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < 8; i++) mRegs[i] = 32'h0;
      mRegs[3] = 32'hFFFF_FFFF;
      modelValid = 1'b1;
    end else begin
      mWr   = iWriteEnable && (iAddress[31:5] == BASE[31:5]);
      mOff  = iAddress[4:2];
      mLane = {{8{iByteEnable[3]}}, {8{iByteEnable[2]}}, {8{iByteEnable[1]}}, {8{iByteEnable[0]}}};
      mTick = mRegs[0][0] && (mRegs[5] == mRegs[1]);
      mHit  = mTick && (mRegs[2] == mRegs[3]);
      for (int i = 0; i < 8; i++) mNxt[i] = mRegs[i];
      if (mTick) begin
        mNxt[5] = 32'h0;
        mNxt[2] = (mHit && mRegs[0][1]) ? 32'h0 : mRegs[2] + 32'd1;
      end else if (mRegs[0][0]) begin
        mNxt[5] = (mRegs[5] + 32'd1) & 32'hFFFF;
      end
      if (mHit) mNxt[4] = 32'h1;
      else if (mWr && mOff == 3'd4 && iByteEnable[0] && iWriteData[0]) mNxt[4] = 32'h0;
      if (mWr && wMask[mOff] != 32'h0) begin
        mUse = mLane & wMask[mOff];
        mNxt[mOff] = (mRegs[mOff] & ~mUse) | (iWriteData & mUse);
        if (mOff == 3'd1) mNxt[5] = 32'h0;
      end
      for (int i = 0; i < 8; i++) mRegs[i] = mNxt[i];
    end
  end

  always @(negedge iCLK) begin
    logic        expSel;
    logic [31:0] expRd;
    if (modelValid) begin
      expSel = (iAddress[31:5] == BASE[31:5]);
      expRd  = (expSel && iReadEnable && iAddress[4:2] < 3'd6) ? mRegs[iAddress[4:2]] : 32'h0;
      check("model sel", {31'd0, oSelected}, {31'd0, expSel});
      check("model rdata", oReadData, expRd);
      check("model irq", {24'd0, oPendingInterrupt},
            (mRegs[4][0] && mRegs[0][2]) ? 32'h80 : 32'h0);
    end
  end

  task automatic busWrite(input int off, input logic [31:0] data, input logic [3:0] be);
    iReadEnable  = 1'b0;
    iWriteEnable = 1'b1;
    iAddress     = addrOf(off);
    iWriteData   = data;
    iByteEnable  = be;
    @(posedge iCLK); #1;
    iWriteEnable = 1'b0;
    iByteEnable  = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      iReadEnable = 1'b1;
      iAddress    = addrOf(i % 8);
      @(posedge iCLK); #1;
    end
  endtask

  task automatic expectRead(input logic [31:0] addr, input logic [31:0] exp,
                            input logic [7:0] expIrq, input string name);
    iWriteEnable = 1'b0;
    iReadEnable  = 1'b1;
    iAddress     = addr;
    @(negedge iCLK);
    check(name, oReadData, exp);
    check({name, " irq"}, {24'd0, oPendingInterrupt}, {24'd0, expIrq});
    @(posedge iCLK); #1;
  endtask

  initial begin
    iRST = 1'b1; iReadEnable = 1'b0; iWriteEnable = 1'b0;
    iByteEnable = 4'h0; iAddress = 32'h0; iWriteData = 32'h0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;

    expectRead(addrOf(0), 32'h0, 8'h00, "rst ctrl");
    expectRead(addrOf(1), 32'h0, 8'h00, "rst presc");
    expectRead(addrOf(2), 32'h0, 8'h00, "rst count");
    expectRead(addrOf(3), 32'hFFFF_FFFF, 8'h00, "rst cmp");
    expectRead(addrOf(4), 32'h0, 8'h00, "rst status");
    expectRead(addrOf(5), 32'h0, 8'h00, "rst pcnt");

    busWrite(1, 32'd3, 4'hF);
    busWrite(2, 32'd0, 4'hF);
    busWrite(0, 32'd1, 4'hF);
    idle(12);
    expectRead(addrOf(2), 32'd3, 8'h00, "presc count");
    expectRead(addrOf(5), 32'd1, 8'h00, "pcnt 1");
    expectRead(addrOf(5), 32'd2, 8'h00, "pcnt 2");
    expectRead(addrOf(5), 32'd3, 8'h00, "pcnt 3");
    expectRead(addrOf(5), 32'd0, 8'h00, "pcnt 0");
    expectRead(addrOf(2), 32'd4, 8'h00, "presc count 4");
    busWrite(0, 32'd0, 4'hF);

    busWrite(1, 32'd0, 4'hF);
    busWrite(3, 32'd5, 4'hF);
    busWrite(2, 32'd0, 4'hF);
    busWrite(0, 32'd7, 4'hF);
    idle(5);
    expectRead(addrOf(2), 32'd5, 8'h00, "ar before match");
    expectRead(addrOf(2), 32'd0, 8'h80, "ar reload");
    expectRead(addrOf(4), 32'd1, 8'h80, "ar flag");
    busWrite(0, 32'd4, 4'hF);
    busWrite(4, 32'd1, 4'h1);
    expectRead(addrOf(4), 32'd0, 8'h00, "w1c clear");

    busWrite(2, 32'h1122_3344, 4'hF);
    busWrite(2, 32'hAABB_CCDD, 4'b0101);
    expectRead(addrOf(2), 32'h11BB_33DD, 8'h00, "byte lanes");
    expectRead(addrOf(2) + 32'd3, 32'h11BB_33DD, 8'h00, "low addr bits");
    expectRead(addrOf(6), 32'h0, 8'h00, "unlisted offset");
    expectRead(32'h0000_0008, 32'h0, 8'h00, "unselected");

    busWrite(3, 32'hFFFF_FFFF, 4'hF);
    busWrite(2, 32'hFFFF_FFFE, 4'hF);
    busWrite(0, 32'd5, 4'hF);
    expectRead(addrOf(2), 32'hFFFF_FFFE, 8'h00, "wrap start");
    expectRead(addrOf(2), 32'hFFFF_FFFF, 8'h00, "wrap max no flag");
    expectRead(addrOf(2), 32'h0, 8'h80, "wrap match");
    expectRead(addrOf(4), 32'd1, 8'h80, "wrap flag");
    busWrite(0, 32'd0, 4'hF);
    busWrite(4, 32'd1, 4'h1);

    busWrite(3, 32'd3, 4'hF);
    busWrite(2, 32'd0, 4'hF);
    busWrite(0, 32'd1, 4'hF);
    idle(3);
    busWrite(4, 32'd1, 4'h1);
    expectRead(addrOf(4), 32'd1, 8'h00, "set beats w1c");
    busWrite(0, 32'd0, 4'hF);
    busWrite(4, 32'd1, 4'h1);
    expectRead(addrOf(4), 32'd0, 8'h00, "flag cleared");

    busWrite(0, 32'd1, 4'hF);
    busWrite(2, 32'h10, 4'hF);
    expectRead(addrOf(2), 32'h10, 8'h00, "write beats tick");
    busWrite(0, 32'd0, 4'hF);
    expectRead(addrOf(2), 32'h12, 8'h00, "en clear tick kept");

    busWrite(1, 32'd2, 4'hF);
    busWrite(2, 32'd7, 4'hF);
    busWrite(0, 32'd1, 4'hF);
    idle(2);
    iRST = 1'b1; iWriteEnable = 1'b1; iAddress = addrOf(3);
    iWriteData = 32'h0; iByteEnable = 4'hF;
    @(posedge iCLK); #1;
    iRST = 1'b0; iWriteEnable = 1'b0; iByteEnable = 4'h0;
    expectRead(addrOf(0), 32'h0, 8'h00, "mid rst ctrl");
    expectRead(addrOf(1), 32'h0, 8'h00, "mid rst presc");
    expectRead(addrOf(2), 32'h0, 8'h00, "mid rst count");
    expectRead(addrOf(3), 32'hFFFF_FFFF, 8'h00, "mid rst cmp");
    expectRead(addrOf(4), 32'h0, 8'h00, "mid rst status");
    expectRead(addrOf(5), 32'h0, 8'h00, "mid rst pcnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
